// File: rtl/bcd_char_streamer.sv
// bcd_char_streamer: snapshots a packed BCD count and streams one ASCII char per digit, MSD first.
// Latency: first character valid one cycle after latch_in; one character per cycle while ready.
// Backpressure: valid/ready; all char_* outputs hold while char_ready_in is low.
module bcd_char_streamer #(
  parameter int DIGITS        = 8,
  parameter bit BLANK_LEADING = 1'b1,
  parameter int IDXW          = $clog2(DIGITS)
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic                  overflow_in,
  input  logic                  latch_in,
  output logic                  char_valid_out,
  input  logic                  char_ready_in,
  output logic [7:0]            char_code_out,
  output logic [IDXW-1:0]       char_index_out,
  output logic                  char_last_out,
  output logic                  busy_out,
  output logic                  missed_latch_out
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  state_t                state_q;
  logic [4*DIGITS-1:0]   snap_q;
  logic                  ovf_q;
  logic [IDXW-1:0]       idx_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  last_q;
  logic [7:0]            code_q;

  logic                  xfer;
  logic                  final_xfer;
  logic [IDXW-1:0]       idx_d;

  // ASCII for screen position pos of a snapshot; position 0 is the most significant digit.
  // Blanking needs every strictly more significant digit to be zero; any non-zero nibble,
  // including an invalid one, ends the blanked run.
  function automatic logic [7:0] char_at(input logic [4*DIGITS-1:0] snap,
                                         input logic                ovf,
                                         input logic [IDXW-1:0]     pos);
    logic [3:0] d;
    logic       zero_above;
    logic [7:0] c;
    d          = 4'd0;
    zero_above = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k < int'(pos) && snap[4*(DIGITS-1-k) +: 4] != 4'd0) zero_above = 1'b0;
      if (k == int'(pos)) d = snap[4*(DIGITS-1-k) +: 4];
    end
    if (ovf)
      c = 8'h2D;
    else if (d > 4'd9)
      c = 8'h3F;
    else if (BLANK_LEADING && zero_above && d == 4'd0 && pos != LAST_IDX)
      c = 8'h20;
    else
      c = {4'h3, d};
    return c;
  endfunction

  assign xfer       = valid_q & char_ready_in;
  assign final_xfer = xfer & (idx_q == LAST_IDX);
  assign idx_d      = idx_q + IDXW'(1);

  // A strobe that arrives mid-frame is dropped; flag it in the same cycle it is seen.
  assign missed_latch_out = busy_q & latch_in & ~final_xfer & ~reset_in;

  assign char_valid_out = valid_q;
  assign char_code_out  = code_q;
  assign char_index_out = idx_q;
  assign char_last_out  = last_q;
  assign busy_out       = busy_q;

  // Frame FSM: snapshot on strobe, advance index on each accepted character, chain frames back-to-back.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      snap_q  <= '0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
      code_q  <= 8'h20;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (latch_in) begin
            state_q <= S_STREAM;
            snap_q  <= digits_in;
            ovf_q   <= overflow_in;
            idx_q   <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            last_q  <= 1'b0;
            code_q  <= char_at(digits_in, overflow_in, '0);
          end
        end
        S_STREAM: begin
          if (final_xfer) begin
            if (latch_in) begin
              // Back-to-back frame: new snapshot, restart at the left edge with no gap.
              snap_q  <= digits_in;
              ovf_q   <= overflow_in;
              idx_q   <= '0;
              last_q  <= 1'b0;
              code_q  <= char_at(digits_in, overflow_in, '0);
            end else begin
              state_q <= S_IDLE;
              idx_q   <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              code_q  <= 8'h20;
            end
          end else if (xfer) begin
            idx_q  <= idx_d;
            last_q <= (idx_d == LAST_IDX);
            code_q <= char_at(snap_q, ovf_q, idx_d);
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_char_streamer.sv
// Bench for bcd_char_streamer: two instances (blanking on/off) share stimulus.
// A frame-level model predicts every output each cycle from the snapshot value.
// Inputs are driven and outputs sampled at the falling edge.
module tb_bcd_char_streamer;
  localparam int D  = 8;
  localparam int IW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, latch, ovf, rdy;
  logic [4*D-1:0] dg;

  logic          a_vld, a_last, a_busy, a_miss;
  logic [7:0]    a_code;
  logic [IW-1:0] a_idx;
  logic          b_vld, b_last, b_busy, b_miss;
  logic [7:0]    b_code;
  logic [IW-1:0] b_idx;

  bcd_char_streamer #(.DIGITS(D), .BLANK_LEADING(1'b1)) dut_a (
    .clk_in(clk), .reset_in(rst), .digits_in(dg), .overflow_in(ovf), .latch_in(latch),
    .char_valid_out(a_vld), .char_ready_in(rdy), .char_code_out(a_code),
    .char_index_out(a_idx), .char_last_out(a_last), .busy_out(a_busy),
    .missed_latch_out(a_miss));

  bcd_char_streamer #(.DIGITS(D), .BLANK_LEADING(1'b0)) dut_b (
    .clk_in(clk), .reset_in(rst), .digits_in(dg), .overflow_in(ovf), .latch_in(latch),
    .char_valid_out(b_vld), .char_ready_in(rdy), .char_code_out(b_code),
    .char_index_out(b_idx), .char_last_out(b_last), .busy_out(b_busy),
    .missed_latch_out(b_miss));

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: whether a frame is on screen, its position and its snapshot.
  bit          m_busy  = 1'b0;
  bit          m_fresh = 1'b1;
  int          m_pos   = 0;
  logic [31:0] m_dg    = '0;
  bit          m_ov    = 1'b0;

  // Character for position pos: the digit and everything above it form the value
  // (dg >> 4*(D-1-pos)); if that is zero the position is a leading zero.
  function automatic logic [31:0] exp_char(input logic [31:0] v, input bit ov,
                                           input bit blank, input int pos);
    int          sh;
    logic [31:0] d;
    sh = 4 * (D - 1 - pos);
    d  = (v >> sh) & 32'hF;
    if (ov)                                        return 32'h2D;
    if (d > 9)                                     return 32'h3F;
    if (blank && pos < D - 1 && (v >> sh) == 0)    return 32'h20;
    return 32'h30 + d;
  endfunction

  task automatic step(input bit r, input bit l, input logic [31:0] d, input bit o, input bit y);
    bit last_pos;
    @(negedge clk);
    rst = r; latch = l; dg = d; ovf = o; rdy = y;
    #1;
    last_pos = (m_pos == D - 1);
    chk("valid",   32'(a_vld),  32'(m_busy));
    chk("busy",    32'(a_busy), 32'(m_busy));
    chk("last",    32'(a_last), 32'(m_busy && last_pos));
    chk("missed",  32'(a_miss), 32'(!r && m_busy && l && !(y && last_pos)));
    chk("valid_b", 32'(b_vld),  32'(m_busy));
    chk("last_b",  32'(b_last), 32'(m_busy && last_pos));
    if (m_busy) begin
      chk("code",   32'(a_code), exp_char(m_dg, m_ov, 1'b1, m_pos));
      chk("code_b", 32'(b_code), exp_char(m_dg, m_ov, 1'b0, m_pos));
      chk("index",  32'(a_idx),  32'(m_pos));
    end else if (m_fresh) begin
      chk("rst_code",   32'(a_code), 32'h20);
      chk("rst_code_b", 32'(b_code), 32'h20);
      chk("rst_index",  32'(a_idx),  32'd0);
      chk("rst_missed", 32'(b_miss), 32'd0);
    end
    @(posedge clk);
    if (r) begin
      m_busy = 1'b0; m_pos = 0; m_fresh = 1'b1;
    end else if (!m_busy) begin
      if (l) begin m_busy = 1'b1; m_pos = 0; m_dg = d; m_ov = o; m_fresh = 1'b0; end
    end else if (y) begin
      if (last_pos) begin
        if (l) begin m_pos = 0; m_dg = d; m_ov = o; end
        else m_busy = 1'b0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (m_busy && n < 100) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'($urandom_range(0, 1)));
      n++;
    end
    chk("drain_done", 32'(m_busy), 32'd0);
  endtask

  task automatic run_to(input int pos);
    int n = 0;
    while (m_pos != pos && n < 20) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      n++;
    end
    chk("reach_pos", 32'(m_pos), 32'(pos));
  endtask

  function automatic logic [31:0] rand_count();
    logic [31:0] v;
    int          n;
    v = '0;
    n = $urandom_range(0, D);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 15) < 2) v[4*k +: 4] = 4'($urandom_range(10, 15));
      else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    rst = 1'b1; latch = 1'b0; dg = '0; ovf = 1'b0; rdy = 1'b0;
    repeat (2) @(posedge clk);

    // Plain count with leading blanks, then all zeros, then overflow.
    step(1'b0, 1'b1, 32'h00012345, 1'b0, 1'b1);
    repeat (9) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
    repeat (9) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h98765432, 1'b1, 1'b1);
    repeat (9) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Embedded zeros and an invalid nibble under random stalls.
    step(1'b0, 1'b1, 32'h10203A04, 1'b0, 1'($urandom_range(0, 1)));
    drain();

    // Strobe mid-frame is dropped; strobe on the final transfer chains a new frame.
    step(1'b0, 1'b1, 32'h00000777, 1'b0, 1'b1);
    run_to(3);
    step(1'b0, 1'b1, 32'h55555555, 1'b0, 1'b0);
    run_to(D - 1);
    step(1'b0, 1'b1, 32'h00000042, 1'b0, 1'b1);
    drain();

    // Reset while stalled mid-frame, then a clean frame.
    step(1'b0, 1'b1, 32'h87654321, 1'b0, 1'b1);
    run_to(4);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h00000009, 1'b0, 1'b1);
    drain();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r, l;
      r = ($urandom_range(0, 149) == 0);
      l = !r && ($urandom_range(0, 7) == 0);
      step(r, l, rand_count(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
